ring_slot_scheduler: RTL and testbench

- Time-slot scheduler that sits directly downstream of the one-hot ring counter.
- Drives the ring counter's enable input and consumes its one-hot output as the current slot pointer.
- Grants a shared resource to the requester whose slot is current, holds that grant for a bounded time, then advances the ring to the next slot.
- Result: round-robin fair access with a worst-case hold limit, plus a sticky integrity flag when the ring is not one-hot.

---
 rtl/ring_slot_scheduler_if.sv | 14 +
 rtl/ring_slot_scheduler.sv | 78 +++++++
 tb/tb_ring_slot_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ring_slot_scheduler_if.sv
// ring_slot_scheduler_if: request/grant bundle between requesters and the slot scheduler.
interface ring_slot_scheduler_if #(
    parameter int WIDTH = 4,
    parameter int ID_W  = $clog2(WIDTH)
);
    logic [WIDTH-1:0] i_req;
    logic             i_done;
    logic [WIDTH-1:0] o_gnt;
    logic             o_gnt_valid;
    logic [ID_W-1:0]  o_gnt_id;
    logic             o_timeout;
    modport master (output i_req, i_done, input o_gnt, o_gnt_valid, o_gnt_id, o_timeout);
    modport slave  (input i_req, i_done, output o_gnt, o_gnt_valid, o_gnt_id, o_timeout);
endinterface

// File: rtl/ring_slot_scheduler.sv
// ring_slot_scheduler: grants the requester under the ring pointer for at most MAX_HOLD cycles, then advances the ring.
module ring_slot_scheduler #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = $clog2(WIDTH),
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_ring_slot,
    output logic                   o_ring_enable,
    output logic                   o_onehot_err,
    ring_slot_scheduler_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_gnt;
    logic              r_gnt_valid;
    logic [ID_W-1:0]   r_gnt_id;
    logic [HOLD_W-1:0] r_hold;
    logic              r_onehot_err;
    logic              w_onehot, w_any, w_hit, w_last, w_own, w_release;
    logic [ID_W-1:0]   w_slot_id;
    assign w_onehot  = (i_ring_slot != '0) && ((i_ring_slot & (i_ring_slot - WIDTH'(1))) == '0);
    assign w_any     = |bus.i_req;
    assign w_hit     = w_onehot & |(i_ring_slot & bus.i_req);
    assign w_last    = r_hold == HOLD_W'(MAX_HOLD - 1);
    assign w_own     = bus.i_req[r_gnt_id];
    assign w_release = bus.i_done | ~w_own | w_last;
    assign o_ring_enable = (r_state == S_SCAN)  ? (w_any & ~w_hit) :
                           (r_state == S_GRANT) ? w_release : 1'b0;
    assign bus.o_timeout   = (r_state == S_GRANT) & w_last & ~bus.i_done & w_own;
    assign bus.o_gnt       = r_gnt;
    assign bus.o_gnt_valid = r_gnt_valid;
    assign bus.o_gnt_id    = r_gnt_id;
    assign o_onehot_err    = r_onehot_err;
    always_comb begin
        w_slot_id = '0;
        for (int i = 0; i < WIDTH; i++)
            if (i_ring_slot[i]) w_slot_id = ID_W'(i);
    end
    // Grant id is kept after release; only o_gnt/o_gnt_valid drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_gnt_valid  <= 1'b0;
            r_gnt_id     <= '0;
            r_hold       <= '0;
            r_onehot_err <= 1'b0;
        end else begin
            r_onehot_err <= r_onehot_err | ~w_onehot;
            case (r_state)
                S_IDLE: if (w_any) r_state <= S_SCAN;
                S_SCAN: begin
                    if (!w_any) r_state <= S_IDLE;
                    else if (w_hit) begin
                        r_state     <= S_GRANT;
                        r_gnt       <= i_ring_slot;
                        r_gnt_id    <= w_slot_id;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_state     <= S_SCAN;
                        r_gnt       <= '0;
                        r_gnt_valid <= 1'b0;
                    end else r_hold <= r_hold + HOLD_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_slot_scheduler.sv
// tb_ring_slot_scheduler: ring counter looped back to the scheduler, table-driven cycle vectors plus reset/limit sequences.
module tb_ring_slot_scheduler;
    localparam int W = 4;
    typedef struct packed {
        logic [3:0] ring;
        logic       en;
        logic       to;
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       err;
    } out_t;
    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic       frc;
        out_t       o;
    } vec_t;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] ring, slot;
    logic [W-1:0] frc_val = 4'b0011;
    logic         frc = 1'b0;
    logic         en, err;
    int           n_cmp = 0;
    int           n_bad = 0;
    vec_t         tbl[$];
    out_t         exp_q[$];
    always #5 clk = ~clk;
    ring_slot_scheduler_if #(.WIDTH(W)) bus();
    ring_slot_scheduler #(.WIDTH(W), .MAX_HOLD(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ring_slot(slot),
        .o_ring_enable(en), .o_onehot_err(err), .bus(bus)
    );
    // Reference one-hot ring counter, with an override to corrupt the pointer.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ring <= 4'b0001;
        else if (en) ring <= {ring[W-2:0], ring[W-1]};
    assign slot = frc ? frc_val : ring;
    function automatic out_t mk(logic [3:0] r, logic e, logic t, logic [3:0] g, logic vl, logic [1:0] id, logic er);
        mk = '{r, e, t, g, vl, id, er};
    endfunction
    function automatic vec_t vc(logic [3:0] req, logic dn, logic fr, out_t o);
        vc = '{req, dn, fr, o};
    endfunction
    task automatic check(string nm);
        out_t a, e;
        e = exp_q.pop_front();
        a = '{slot, en, bus.o_timeout, bus.o_gnt, bus.o_gnt_valid, bus.o_gnt_id, err};
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got ring=%b en=%b to=%b gnt=%b vld=%b id=%0d err=%b, want ring=%b en=%b to=%b gnt=%b vld=%b id=%0d err=%b",
                     nm, a.ring, a.en, a.to, a.gnt, a.vld, a.id, a.err, e.ring, e.en, e.to, e.gnt, e.vld, e.id, e.err);
        end
        if (bus.o_gnt_valid) begin
            n_cmp++;
            if (bus.o_gnt !== (W'(1) << bus.o_gnt_id)) begin
                n_bad++;
                $display("FAIL %s_inv: got gnt=%b with id=%0d, want gnt=1<<id", nm, bus.o_gnt, bus.o_gnt_id);
            end
        end
    endtask
    task automatic step(logic [3:0] req, logic dn, out_t o, string nm);
        @(negedge clk);
        bus.i_req = req;
        bus.i_done = dn;
        exp_q.push_back(o);
        #2 check(nm);
    endtask
    initial begin
        bus.i_req = '0;
        bus.i_done = 1'b0;
        // basic grant, early release on the 3rd grant cycle
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0001, 0, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0001, 1, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0010, 1, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0100, 0, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0100, 0, 0, 4'b0100, 1, 2, 0)));
        tbl.push_back(vc(4'b0100, 0, 0, mk(4'b0100, 0, 0, 4'b0100, 1, 2, 0)));
        tbl.push_back(vc(4'b0100, 1, 0, mk(4'b0100, 1, 0, 4'b0100, 1, 2, 0)));
        tbl.push_back(vc(4'b0000, 0, 0, mk(4'b1000, 0, 0, 4'b0000, 0, 2, 0)));
        tbl.push_back(vc(4'b0000, 0, 0, mk(4'b1000, 0, 0, 4'b0000, 0, 2, 0)));
        // timeout after 8 grant cycles
        tbl.push_back(vc(4'b0001, 0, 0, mk(4'b1000, 0, 0, 4'b0000, 0, 2, 0)));
        tbl.push_back(vc(4'b0001, 0, 0, mk(4'b1000, 1, 0, 4'b0000, 0, 2, 0)));
        tbl.push_back(vc(4'b0001, 0, 0, mk(4'b0001, 0, 0, 4'b0000, 0, 2, 0)));
        for (int k = 0; k < 7; k++)
            tbl.push_back(vc(4'b0001, 0, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 0)));
        tbl.push_back(vc(4'b0001, 0, 0, mk(4'b0001, 1, 1, 4'b0001, 1, 0, 0)));
        tbl.push_back(vc(4'b0000, 0, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0)));
        // round-robin with immediate release
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b1111, 1, 0, mk(4'b0010, 1, 0, 4'b0010, 1, 1, 0)));
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b0100, 0, 0, 4'b0000, 0, 1, 0)));
        tbl.push_back(vc(4'b1111, 1, 0, mk(4'b0100, 1, 0, 4'b0100, 1, 2, 0)));
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b1000, 0, 0, 4'b0000, 0, 2, 0)));
        tbl.push_back(vc(4'b1111, 1, 0, mk(4'b1000, 1, 0, 4'b1000, 1, 3, 0)));
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b0001, 0, 0, 4'b0000, 0, 3, 0)));
        tbl.push_back(vc(4'b1111, 1, 0, mk(4'b0001, 1, 0, 4'b0001, 1, 0, 0)));
        tbl.push_back(vc(4'b1111, 0, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0)));
        tbl.push_back(vc(4'b1111, 1, 0, mk(4'b0010, 1, 0, 4'b0010, 1, 1, 0)));
        tbl.push_back(vc(4'b0000, 0, 0, mk(4'b0100, 0, 0, 4'b0000, 0, 1, 0)));
        tbl.push_back(vc(4'b0000, 0, 0, mk(4'b0100, 0, 0, 4'b0000, 0, 1, 0)));
        // corrupted ring pointer for one cycle
        tbl.push_back(vc(4'b0011, 0, 0, mk(4'b0100, 0, 0, 4'b0000, 0, 1, 0)));
        tbl.push_back(vc(4'b0011, 0, 1, mk(4'b0011, 1, 0, 4'b0000, 0, 1, 0)));
        tbl.push_back(vc(4'b0011, 0, 0, mk(4'b1000, 1, 0, 4'b0000, 0, 1, 1)));
        tbl.push_back(vc(4'b0011, 0, 0, mk(4'b0001, 0, 0, 4'b0000, 0, 1, 1)));
        tbl.push_back(vc(4'b0011, 0, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 1)));
        tbl.push_back(vc(4'b0011, 0, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 1)));
        repeat (2) @(negedge clk);
        exp_q.push_back(mk(4'b0001, 0, 0, 4'b0000, 0, 0, 0));
        check("reset");
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.i_req = tbl[i].req;
            bus.i_done = tbl[i].done;
            frc = tbl[i].frc;
            exp_q.push_back(tbl[i].o);
            #2 check($sformatf("row%0d", i));
        end
        // 3rd grant cycle, then asynchronous reset mid-cycle
        step(4'b0011, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 1), "pre_rst");
        #1 rst_n = 1'b0;
        #1 exp_q.push_back(mk(4'b0001, 0, 0, 4'b0000, 0, 0, 0));
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(4'b0001, 0, 0, 4'b0000, 0, 0, 0));
        #2 check("post_rst_idle");
        step(4'b0011, 0, mk(4'b0001, 0, 0, 4'b0000, 0, 0, 0), "post_rst_scan");
        step(4'b0011, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 0), "post_rst_grant");
        for (int k = 1; k < 7; k++)
            step(4'b0011, 0, mk(4'b0001, 0, 0, 4'b0001, 1, 0, 0), $sformatf("hold%0d", k));
        // done coinciding with the hold limit is a normal release
        step(4'b0011, 1, mk(4'b0001, 1, 0, 4'b0001, 1, 0, 0), "done_at_limit");
        step(4'b0000, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0), "after_limit");
        step(4'b0000, 0, mk(4'b0010, 0, 0, 4'b0000, 0, 0, 0), "idle_again");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
